ascii_num_parser: RTL and testbench

Parametrised successor to the ASCII hex accumulator. Parses a stream of ASCII characters, one per beat, into a WIDTH-bit unsigned binary word. Radix (hex or decimal) is selectable per word, an optional "0x" prefix is accepted, and overflow and invalid characters are detected. Output uses a valid/ready handshake with full backpressure, feeding the downstream binary-to-decimal stage.

---
 rtl/ascii_num_parser.sv | 87 ++++++++
 tb/tb_ascii_num_parser.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ascii_num_parser.sv
// ascii_num_parser: streams ASCII characters into a WIDTH-bit binary word with hex/decimal radix, optional 0x prefix, error and overflow flags
module ascii_num_parser #(
   parameter int WIDTH        = 32,
   parameter bit ALLOW_PREFIX = 1'b1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [7:0]       in_data_i,
   input  logic             in_valid_i,
   input  logic             in_last_i,
   output logic             in_ready_o,
   input  logic             mode_i,
   output logic [WIDTH-1:0] out_data_o,
   output logic [7:0]       out_digits_o,
   output logic             out_err_o,
   output logic             out_ovf_o,
   output logic             out_valid_o,
   input  logic             out_ready_i
);
   typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_OUT} state_t;
   state_t state;
   logic [WIDTH-1:0] acc, b_acc, n_acc;
   logic [7:0] digits, b_dig, n_dig;
   logic err, ovf, mode, pfx;
   logic b_err, b_ovf, md, n_err, n_ovf;
   logic first, is_num, is_up, is_lo, is_dig, is_pfx, over;
   logic [3:0] dv;
   logic [WIDTH+3:0] wide;

   assign in_ready_o  = state != S_OUT;
   assign out_valid_o = state == S_OUT;

   // next word state for the character on in_data_i; the first beat of a word starts from cleared values
   always_comb begin
      first  = state == S_IDLE;
      md     = first ? mode_i : mode;
      b_acc  = first ? '0 : acc;
      b_dig  = first ? '0 : digits;
      b_err  = first ? 1'b0 : err;
      b_ovf  = first ? 1'b0 : ovf;
      is_num = in_data_i >= 8'h30 && in_data_i <= 8'h39;
      is_up  = in_data_i >= 8'h41 && in_data_i <= 8'h46;
      is_lo  = in_data_i >= 8'h61 && in_data_i <= 8'h66;
      dv     = is_num ? 4'(in_data_i - 8'h30) : is_up ? 4'(in_data_i - 8'h37) : 4'(in_data_i - 8'h57);
      is_dig = is_num | (!md & (is_up | is_lo));
      is_pfx = ALLOW_PREFIX && !md && !first && pfx && (in_data_i == 8'h78 || in_data_i == 8'h58);
      wide   = md ? {4'b0, b_acc} * (WIDTH+4)'(10) + (WIDTH+4)'(dv) : {b_acc, dv};
      over   = b_ovf | (|wide[WIDTH+3:WIDTH]);
      n_acc  = is_pfx ? '0 : !is_dig ? b_acc : over ? '1 : wide[WIDTH-1:0];
      n_dig  = is_pfx ? '0 : (is_dig && b_dig != 8'hFF) ? b_dig + 8'd1 : b_dig;
      n_err  = b_err | (!is_dig & !is_pfx);
      n_ovf  = b_ovf | (is_dig & over);
   end

   // word FSM: accumulate beats, publish the result on the last one, hold it until the handshake
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= S_IDLE;
         acc          <= '0;
         digits       <= '0;
         err          <= 1'b0;
         ovf          <= 1'b0;
         mode         <= 1'b0;
         pfx          <= 1'b0;
         out_data_o   <= '0;
         out_digits_o <= '0;
         out_err_o    <= 1'b0;
         out_ovf_o    <= 1'b0;
      end else if (state == S_OUT) begin
         if (out_ready_i) state <= S_IDLE;
      end else if (in_valid_i) begin
         acc    <= n_acc;
         digits <= n_dig;
         err    <= n_err;
         ovf    <= n_ovf;
         mode   <= md;
         pfx    <= first && in_data_i == 8'h30;
         state  <= in_last_i ? S_OUT : S_ACCUM;
         if (in_last_i) begin
            out_data_o   <= n_acc;
            out_digits_o <= n_dig;
            out_err_o    <= n_err | (n_dig == 8'd0);
            out_ovf_o    <= n_ovf;
         end
      end
   end
endmodule

// File: tb/tb_ascii_num_parser.sv
// tb_ascii_num_parser: randomized and directed scoreboard bench for ascii_num_parser
module tb_ascii_num_parser;
   typedef byte unsigned bq_t[$];
   typedef struct {
      logic [31:0] data;
      logic [7:0]  digits;
      logic        err;
      logic        ovf;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [7:0]  in_data_i = '0;
   logic        in_valid_i = 1'b0;
   logic        in_last_i = 1'b0;
   logic        in_ready_o;
   logic        mode_i = 1'b0;
   logic [31:0] out_data_o;
   logic [7:0]  out_digits_o;
   logic        out_err_o;
   logic        out_ovf_o;
   logic        out_valid_o;
   logic        out_ready_i;

   int   total = 0;
   int   bad = 0;
   int   rmode = 2;
   exp_t sb[$];

   ascii_num_parser #(.WIDTH(32), .ALLOW_PREFIX(1'b1)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_data_i(in_data_i), .in_valid_i(in_valid_i), .in_last_i(in_last_i), .in_ready_o(in_ready_o),
      .mode_i(mode_i),
      .out_data_o(out_data_o), .out_digits_o(out_digits_o), .out_err_o(out_err_o), .out_ovf_o(out_ovf_o),
      .out_valid_o(out_valid_o), .out_ready_i(out_ready_i)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int dval(input byte unsigned c, input bit dec);
      if (c >= "0" && c <= "9") return int'(c) - int'("0");
      if (!dec && c >= "a" && c <= "f") return int'(c) - int'("a") + 10;
      if (!dec && c >= "A" && c <= "F") return int'(c) - int'("A") + 10;
      return -1;
   endfunction

   // reference: value as unbounded integer, overflow once it passes 2^32-1, saturate at the end
   function automatic exp_t model(input bq_t w, input bit dec);
      exp_t r;
      longint unsigned v = 0;
      int nd = 0;
      bit e = 0, o = 0;
      for (int i = 0; i < w.size(); i++) begin
         int d = dval(w[i], dec);
         if (!dec && i == 1 && w[0] == "0" && (w[i] == "x" || w[i] == "X")) begin
            v = 0;
            nd = 0;
         end else if (d < 0) begin
            e = 1;
         end else begin
            if (!o) begin
               v = v * (dec ? 10 : 16) + longint'(d);
               if (v > 64'hFFFF_FFFF) o = 1;
            end
            if (nd < 255) nd++;
         end
      end
      r.data   = o ? 32'hFFFF_FFFF : v[31:0];
      r.digits = 8'(nd);
      r.err    = e || nd == 0;
      r.ovf    = o;
      return r;
   endfunction

   function automatic bq_t s2q(input string s);
      bq_t q;
      for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
      return q;
   endfunction

   task automatic wait_ready();
      int n = 0;
      while (!in_ready_o && n < 1000) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (!in_ready_o) begin
         total++;
         bad++;
         $display("FAIL ready_timeout: in_ready_o stuck low at %0t", $time);
      end
   endtask

   task automatic send(input bq_t w, input bit dec, input bit last);
      if (last) sb.push_back(model(w, dec));
      for (int i = 0; i < w.size(); i++) begin
         wait_ready();
         in_valid_i = 1'b1;
         in_data_i  = w[i];
         in_last_i  = last && i == w.size() - 1;
         mode_i     = i == 0 ? dec : 1'($urandom);
         @(posedge clk);
         #1;
         if (in_last_i) chk("latency", 64'(out_valid_o), 64'd1);
         in_valid_i = 1'b0;
         in_last_i  = 1'b0;
         repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
         end
      end
   endtask

   task automatic drain();
      int n = 0;
      rmode = 2;
      while (sb.size() != 0 && n < 2000) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (sb.size() != 0) begin
         total++;
         bad++;
         $display("FAIL drain_timeout: %0d results outstanding", sb.size());
      end
      @(posedge clk);
      #1;
   endtask

   // downstream ready: random, or forced low/high by the directed tests
   initial begin
      out_ready_i = 1'b0;
      forever begin
         @(posedge clk);
         #2;
         out_ready_i = rmode == 2 ? 1'b1 : rmode == 1 ? 1'b0 : ($urandom_range(0, 3) != 0);
      end
   end

   // monitor: every handshake pops the oldest expected result
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst_n && out_valid_o && out_ready_i) begin
            if (sb.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_result: data %0h with empty scoreboard", out_data_o);
            end else begin
               e = sb.pop_front();
               chk("data", 64'(out_data_o), 64'(e.data));
               chk("digits", 64'(out_digits_o), 64'(e.digits));
               chk("err", 64'(out_err_o), 64'(e.err));
               chk("ovf", 64'(out_ovf_o), 64'(e.ovf));
            end
         end
      end
   end

   initial begin
      string s;
      string alpha = "0123456789abcdefABCDEFxXG ";
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_valid", 64'(out_valid_o), 64'd0);
      chk("rst_data", 64'(out_data_o), 64'd0);
      chk("rst_digits", 64'(out_digits_o), 64'd0);
      chk("rst_flags", {62'd0, out_err_o, out_ovf_o}, 64'd0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("rst_ready", 64'(in_ready_o), 64'd1);

      send(s2q("1A3f"), 1'b0, 1'b1);
      send(s2q("4294967295"), 1'b1, 1'b1);
      send(s2q("4294967296"), 1'b1, 1'b1);
      send(s2q("0x10"), 1'b0, 1'b1);
      send(s2q("0x10"), 1'b1, 1'b1);
      send(s2q("1G2"), 1'b0, 1'b1);
      send(s2q(" "), 1'b0, 1'b1);
      send(s2q("0X"), 1'b0, 1'b1);
      send(s2q("FFFFFFFF"), 1'b0, 1'b1);
      send(s2q("100000000"), 1'b0, 1'b1);
      s = "";
      for (int i = 0; i < 300; i++) s = {s, "0"};
      send(s2q(s), 1'b0, 1'b1);
      drain();

      // backpressure: result must hold steady and block input
      rmode = 1;
      send(s2q("ABC"), 1'b0, 1'b1);
      repeat (5) begin
         @(negedge clk);
         chk("bp_valid", 64'(out_valid_o), 64'd1);
         chk("bp_ready", 64'(in_ready_o), 64'd0);
         chk("bp_data", 64'(out_data_o), 64'hABC);
         chk("bp_digits", 64'(out_digits_o), 64'd3);
      end
      @(posedge clk);
      #1;
      rmode = 2;
      @(posedge clk);
      #1;
      chk("bp_release_ready", 64'(in_ready_o), 64'd1);
      chk("bp_release_valid", 64'(out_valid_o), 64'd0);

      // reset in the middle of a word discards it
      send(s2q("12"), 1'b0, 1'b0);
      rst_n = 1'b0;
      #2;
      chk("mid_rst_valid", 64'(out_valid_o), 64'd0);
      chk("mid_rst_data", 64'(out_data_o), 64'd0);
      chk("mid_rst_digits", 64'(out_digits_o), 64'd0);
      chk("mid_rst_flags", {62'd0, out_err_o, out_ovf_o}, 64'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      send(s2q("7"), 1'b0, 1'b1);
      drain();

      // random words under random backpressure
      rmode = 0;
      for (int n = 0; n < 200; n++) begin
         bq_t w;
         int len = $urandom_range(1, 10);
         if ($urandom_range(0, 3) == 0) begin
            w.push_back("0");
            w.push_back($urandom_range(0, 1) ? "x" : "X");
         end
         for (int i = 0; i < len; i++) begin
            int k = $urandom_range(0, alpha.len() - 1);
            w.push_back(alpha[k]);
         end
         send(w, 1'($urandom), 1'b1);
      end
      drain();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
